// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the
// smallest legal values of the sequencer parameters, and a counter-width
// helper used to size the internal counters.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_RELEASE = 2'd1,
      S_RUN     = 2'd2,
      S_SWRST   = 2'd3
   } state_t;

   localparam int MIN_SYNC_STAGES    = 2;
   localparam int MIN_STRETCH_CYCLES = 1;
   localparam int MIN_STAGGER_CYCLES = 1;
   localparam int MIN_N_OUT          = 1;

   // Bits needed to count 0..value-1, never less than one bit.
   function automatic int width_min1(input int value);
      if (value <= 2) return 1;
      return $clog2(value);
   endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Deassertion synchroniser for rst_n: a chain of STAGES flops that clears
// instantly when rst_n falls and shifts in ones once rst_n is released.
module reset_sync_chain #(
   parameter int STAGES = 3
) (
   input  logic clk,
   input  logic rst_n,
   output logic sync_ok
);

   logic [STAGES-1:0] chain_reg;

   // Shift a constant one through the chain; async clear on rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= {chain_reg[STAGES-2:0], 1'b1};
      end
   end

   assign sync_ok = chain_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator. rst_n asserts every rst_out bit immediately; on
// release the deassertion is synchronised, stretched by STRETCH_CYCLES and
// then the bits are released one at a time, bit 0 first, STAGGER_CYCLES apart.
// Optional feature macro RESET_SEQ_SW_REQ_EN enables the sw_req/sw_ack
// software-reset handshake that replays the whole sequence from S_RUN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int SYNC_STAGES    = 3,
   parameter int STRETCH_CYCLES = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int N_OUT          = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sw_req,
   output logic             sw_ack,
   output logic [N_OUT-1:0] rst_out,
   output logic             rst_done
);

   localparam int CNT_W = width_min1((STRETCH_CYCLES > STAGGER_CYCLES) ?
                                     STRETCH_CYCLES : STAGGER_CYCLES);
   localparam int IDX_W = width_min1(N_OUT);

   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_OUT - 1);

   // Reject parameter values the sequencing cannot honour.
   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
      $error("reset_sequencer: SYNC_STAGES below minimum");
   end
   if (STRETCH_CYCLES < MIN_STRETCH_CYCLES) begin : g_bad_stretch
      $error("reset_sequencer: STRETCH_CYCLES below minimum");
   end
   if (STAGGER_CYCLES < MIN_STAGGER_CYCLES) begin : g_bad_stagger
      $error("reset_sequencer: STAGGER_CYCLES below minimum");
   end
   if (N_OUT < MIN_N_OUT) begin : g_bad_nout
      $error("reset_sequencer: N_OUT below minimum");
   end

   logic             sync_ok;
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [IDX_W-1:0] idx_reg;

`ifdef RESET_SEQ_SW_REQ_EN
   logic sw_ack_reg;
   assign sw_ack = sw_ack_reg;
`else
   // Handshake compiled out: request is ignored and acknowledge held low.
   logic unused_sw_req;
   assign unused_sw_req = sw_req;
   assign sw_ack        = 1'b0;
`endif

   reset_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_ok (sync_ok)
   );

   // Sequencing FSM; every output is a flop so downstream resets never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_HOLD;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         rst_out   <= '1;
         rst_done  <= 1'b0;
`ifdef RESET_SEQ_SW_REQ_EN
         sw_ack_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            S_HOLD: begin
               rst_out <= '1;
               if (sync_ok) begin
                  if (cnt_reg == STRETCH_LAST) begin
                     state_reg <= S_RELEASE;
                     cnt_reg   <= '0;
                     idx_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
            end
            S_RELEASE: begin
               if (cnt_reg == STAGGER_LAST) begin
                  cnt_reg <= '0;
                  for (int i = 0; i < N_OUT; i++) begin
                     if (idx_reg == IDX_W'(i)) rst_out[i] <= 1'b0;
                  end
                  if (idx_reg == LAST_IDX) begin
                     // Last bit goes low on this edge, so done rises with it.
                     state_reg <= S_RUN;
                     rst_done  <= 1'b1;
                     idx_reg   <= '0;
                  end else begin
                     idx_reg <= idx_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            S_RUN: begin
`ifdef RESET_SEQ_SW_REQ_EN
               if (sw_req) begin
                  state_reg  <= S_SWRST;
                  rst_out    <= '1;
                  rst_done   <= 1'b0;
                  sw_ack_reg <= 1'b1;
                  cnt_reg    <= '0;
                  idx_reg    <= '0;
               end
`endif
            end
`ifdef RESET_SEQ_SW_REQ_EN
            S_SWRST: begin
               // Hold everything in reset until the requester drops sw_req;
               // the synchroniser is still full so the stretch starts at once.
               if (!sw_req) begin
                  state_reg  <= S_HOLD;
                  sw_ack_reg <= 1'b0;
                  cnt_reg    <= '0;
               end
            end
`endif
            default: begin
               state_reg <= S_HOLD;
               cnt_reg   <= '0;
               idx_reg   <= '0;
               rst_out   <= '1;
               rst_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: an edge-count model of the
// release schedule checked every cycle, plus literal checkpoints, and a
// second instance at the minimum parameter values.
module tb_reset_sequencer;

   localparam int SYNC    = 3;
   localparam int STRETCH = 16;
   localparam int STAGGER = 4;
   localparam int NOUT    = 4;
`ifdef RESET_SEQ_SW_REQ_EN
   localparam bit SW_EN = 1'b1;
`else
   localparam bit SW_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_req = 1'b0;
   logic       sw_req_min = 1'b0;
   logic       sw_ack;
   logic [3:0] rst_out;
   logic       rst_done;
   logic       sw_ack_min;
   logic [0:0] rst_out_min;
   logic       rst_done_min;

   int tests = 0;
   int fails = 0;
   int e_num = 0;

   reset_sequencer #(
      .SYNC_STAGES(SYNC), .STRETCH_CYCLES(STRETCH),
      .STAGGER_CYCLES(STAGGER), .N_OUT(NOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sw_req(sw_req),
      .sw_ack(sw_ack), .rst_out(rst_out), .rst_done(rst_done)
   );

   reset_sequencer #(
      .SYNC_STAGES(2), .STRETCH_CYCLES(1), .STAGGER_CYCLES(1), .N_OUT(1)
   ) dut_min (
      .clk(clk), .rst_n(rst_n), .sw_req(sw_req_min),
      .sw_ack(sw_ack_min), .rst_out(rst_out_min), .rst_done(rst_done_min)
   );

   always #5 clk = ~clk;

   always @(posedge clk) e_num++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Model: m_n = edges since the sequence origin (rst_n release or the edge
   // that saw sw_req drop); m_lat = synchroniser latency for that origin.
   int m_n   = 0;
   int m_lat = SYNC;
   bit m_sw  = 1'b0;

   function automatic bit model_done();
      return !m_sw && (m_n >= m_lat + STRETCH + NOUT * STAGGER);
   endfunction

   function automatic logic [3:0] model_rst_out();
      logic [3:0] r;
      r = 4'hF;
      if (!m_sw) begin
         for (int i = 0; i < NOUT; i++)
            r[i] = (m_n < m_lat + STRETCH + (i + 1) * STAGGER);
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_lat = SYNC; m_sw = 1'b0;
      end else if (m_sw) begin
         if (!sw_req) begin
            m_sw = 1'b0; m_n = 0; m_lat = 0;
         end
      end else if (SW_EN && sw_req && model_done()) begin
         m_sw = 1'b1;
      end else if (m_n < 10000) begin
         m_n++;
      end
   end

   always @(negedge clk) begin
      check("model_rst_out", rst_out, model_rst_out());
      check("model_rst_done", rst_done, model_done());
      check("model_sw_ack", sw_ack, m_sw);
   end

   task automatic goto_edge(input int base, input int k);
      while (e_num < base + k) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rst_out", rst_out, 4'hF);
      check("reset_rst_done", rst_done, 0);
      check("reset_sw_ack", sw_ack, 0);
      check("reset_min_rst_out", rst_out_min, 1);

      // Power-on release.
      @(posedge clk); #3; rst_n = 1'b1; b = e_num;
      goto_edge(b, 3);  check("min_E3_rst_out", rst_out_min, 1); check("min_E3_done", rst_done_min, 0);
      goto_edge(b, 4);  check("min_E4_rst_out", rst_out_min, 0); check("min_E4_done", rst_done_min, 1);
      goto_edge(b, 22); check("E22_rst_out", rst_out, 4'hF);
      goto_edge(b, 23); check("E23_rst_out", rst_out, 4'hE);
      goto_edge(b, 27); check("E27_rst_out", rst_out, 4'hC);
      goto_edge(b, 31); check("E31_rst_out", rst_out, 4'h8);
      goto_edge(b, 34); check("E34_rst_done", rst_done, 0);
      goto_edge(b, 35); check("E35_rst_out", rst_out, 4'h0); check("E35_rst_done", rst_done, 1);
      check("E35_sw_ack", sw_ack, 0);

      // Asynchronous assertion from S_RUN, no clock edge in between.
      #2; rst_n = 1'b0; #1;
      check("async_rst_out", rst_out, 4'hF); check("async_rst_done", rst_done, 0);
      check("async_min_rst_out", rst_out_min, 1);
      @(posedge clk); #3; rst_n = 1'b1; b = e_num;
      goto_edge(b, 23); check("B_E23_rst_out", rst_out, 4'hE);
      goto_edge(b, 24); #2; rst_n = 1'b0; #1;
      check("mid_async_rst_out", rst_out, 4'hF); check("mid_async_rst_done", rst_done, 0);
      @(posedge clk); #3; rst_n = 1'b1; b = e_num;
      goto_edge(b, 22); check("C_E22_rst_out", rst_out, 4'hF);
      goto_edge(b, 23); check("C_E23_rst_out", rst_out, 4'hE);
      goto_edge(b, 35); check("C_E35_rst_out", rst_out, 4'h0); check("C_E35_rst_done", rst_done, 1);

`ifdef RESET_SEQ_SW_REQ_EN
      // Software reset from S_RUN: high at K=40, low sampled at K+10.
      goto_edge(b, 39); #2; sw_req = 1'b1;
      goto_edge(b, 40); check("K_rst_out", rst_out, 4'hF); check("K_sw_ack", sw_ack, 1);
      check("K_rst_done", rst_done, 0);
      goto_edge(b, 49); #2; sw_req = 1'b0;
      goto_edge(b, 50); check("M_sw_ack", sw_ack, 0); check("M_rst_out", rst_out, 4'hF);
      goto_edge(b, 69); check("K29_rst_out", rst_out, 4'hF);
      goto_edge(b, 70); check("K30_rst_out", rst_out, 4'hE);
      goto_edge(b, 74); check("K34_rst_out", rst_out, 4'hC);
      goto_edge(b, 78); check("K38_rst_out", rst_out, 4'h8);
      goto_edge(b, 82); check("K42_rst_out", rst_out, 4'h0); check("K42_rst_done", rst_done, 1);

      // Request raised during S_RELEASE is held until S_RUN.
      #2; rst_n = 1'b0;
      @(posedge clk); #3; rst_n = 1'b1; b = e_num;
      goto_edge(b, 24); #2; sw_req = 1'b1;
      goto_edge(b, 34); check("R_E34_rst_done", rst_done, 0);
      goto_edge(b, 35); check("R_E35_rst_done", rst_done, 1); check("R_E35_sw_ack", sw_ack, 0);
      goto_edge(b, 36); check("R_E36_rst_done", rst_done, 0); check("R_E36_sw_ack", sw_ack, 1);
      check("R_E36_rst_out", rst_out, 4'hF);
      #2; sw_req = 1'b0;
      goto_edge(b, 37); check("R_E37_sw_ack", sw_ack, 0);
      goto_edge(b, 69); check("R_E69_rst_out", rst_out, 4'h0); check("R_E69_rst_done", rst_done, 1);
`else
      // Request ignored when the handshake is compiled out.
      goto_edge(b, 39); #2; sw_req = 1'b1;
      for (int i = 0; i < 100; i++) begin
         goto_edge(b, 40 + i);
         check("nosw_rst_out", rst_out, 4'h0);
         check("nosw_rst_done", rst_done, 1);
         check("nosw_sw_ack", sw_ack, 0);
      end
      #2; sw_req = 1'b0;
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
